// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, default sizes and the BCD digit-valid check.
package bcd_to_bin_seq_pkg;

    localparam int BCD_ND_DEF = 3;
    localparam int BCD_BW_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic logic digit_valid(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double dabble digit correction: subtract 3 from a digit >= 8.
// Ports: d (4-bit digit in), y (4-bit corrected digit out).
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] y
);

    assign y = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one right shift per clock.
// Ports: clk, reset_n (async low), start, bcd[4*ND-1:0] in;
//        bin[BW-1:0], busy, done (1-cycle pulse), err out.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int ND = BCD_ND_DEF,
    parameter int BW = BCD_BW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [4*ND-1:0] bcd,
    output logic [BW-1:0]   bin,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CW = $clog2(BW + 1);

    state_t          state;
    state_t          state_nx;
    logic [4*ND-1:0] dig_reg;
    logic [4*ND-1:0] dig_sh;
    logic [4*ND-1:0] dig_adj;
    logic [BW-1:0]   bin_sh;
    logic [BW-1:0]   bin_nx;
    logic [CW-1:0]   cnt;
    logic            bcd_ok;
    logic            last;

    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (!digit_valid(bcd[4*i +: 4])) begin
                bcd_ok = 1'b0;
            end
        end
    end

    // Digits and binary accumulator shift as one long register.
    assign {dig_sh, bin_nx} = {dig_reg, bin_sh} >> 1;

    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (dig_sh[4*g +: 4]),
            .y (dig_adj[4*g +: 4])
        );
    end

    assign last = (cnt == CW'(1));

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = bcd_ok ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // bin is captured on the final shift so it is already valid
    // during the cycle in which done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_reg <= '0;
            bin_sh  <= '0;
            cnt     <= '0;
            bin     <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (bcd_ok) begin
                            dig_reg <= bcd;
                            bin_sh  <= '0;
                            cnt     <= CW'(BW);
                            err     <= 1'b0;
                        end else begin
                            err <= 1'b1;
                            bin <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    dig_reg <= dig_adj;
                    bin_sh  <= bin_nx;
                    cnt     <= cnt - CW'(1);
                    if (last) begin
                        bin <= bin_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule
